// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider.
// Each channel emits a divided clock plus rise/fall strobes.
module clock_divider_bank #(
  parameter int   NUM_CH       = 4,
  parameter int   CNT_W        = 16,
  parameter int   DEFAULT_HALF = 1,
  parameter logic INIT_STATE   = 1'b1,
  localparam int  CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Enable,
  input  logic              CfgWrite,
  input  logic [CW-1:0]     CfgChan,
  input  logic [CNT_W-1:0]  CfgHalf,
  input  logic [CNT_W-1:0]  CfgPhase,
  output logic [NUM_CH-1:0] ClockOut,
  output logic [NUM_CH-1:0] RiseTick,
  output logic [NUM_CH-1:0] FallTick,
  output logic [NUM_CH-1:0] Running
);

  typedef enum logic [1:0] {
    IDLE,
    PHASE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEFH = CNT_W'(DEFAULT_HALF);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ha_q, ha_d;
    logic [CNT_W-1:0] pa_q, pa_d;
    logic [CNT_W-1:0] hs_q, hs_d;
    logic [CNT_W-1:0] ps_q, ps_d;
    logic             co_q, co_d;
    logic             rt_q, rt_d;
    logic             ft_q, ft_d;
    logic             rn_q;
    logic             wr;
    logic             last;

    // Next-state, counter, config and output levels.
    always_comb begin
      wr    = CfgWrite && (CfgChan == CW'(c));
      hs_d  = wr ? CfgHalf  : hs_q;
      ps_d  = wr ? CfgPhase : ps_q;
      last  = (ha_q <= ONE) || (cnt_q == ha_q - ONE);
      ha_d  = ha_q;
      pa_d  = pa_q;
      st_d  = st_q;
      cnt_d = cnt_q;
      co_d  = co_q;
      rt_d  = 1'b0;
      ft_d  = 1'b0;
      unique case (st_q)
        IDLE: begin
          ha_d  = hs_d;
          pa_d  = ps_d;
          co_d  = INIT_STATE;
          cnt_d = '0;
          if (Enable[c] && hs_d != '0) begin
            st_d = (ps_d == '0) ? RUN : PHASE;
          end
        end
        PHASE: begin
          co_d = INIT_STATE;
          if (!Enable[c]) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_q == pa_q - ONE) begin
            st_d  = RUN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        RUN: begin
          if (!Enable[c] && co_q == INIT_STATE) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (last) begin
            co_d  = ~co_q;
            rt_d  = ~co_q;
            ft_d  = co_q;
            cnt_d = '0;
            ha_d  = hs_d;
            pa_d  = ps_d;
            if (!Enable[c]) begin
              st_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        ha_q  <= DEFH;
        hs_q  <= DEFH;
        pa_q  <= '0;
        ps_q  <= '0;
        co_q  <= INIT_STATE;
        rt_q  <= 1'b0;
        ft_q  <= 1'b0;
        rn_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        ha_q  <= ha_d;
        hs_q  <= hs_d;
        pa_q  <= pa_d;
        ps_q  <= ps_d;
        co_q  <= co_d;
        rt_q  <= rt_d;
        ft_q  <= ft_d;
        rn_q  <= (st_d != IDLE);
      end
    end

    assign ClockOut[c] = co_q;
    assign RiseTick[c] = rt_q;
    assign FallTick[c] = ft_q;
    assign Running[c]  = rn_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomized scoreboard bench for clock_divider_bank.
// Expected outputs come from a countdown reference model.
module tb_clock_divider_bank;

  localparam int   NCH  = 5;
  localparam int   CW   = 3;
  localparam int   W    = 8;
  localparam int   DH   = 2;
  localparam logic INIT = 1'b1;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [NCH-1:0] Enable;
  logic           CfgWrite;
  logic [CW-1:0]  CfgChan;
  logic [W-1:0]   CfgHalf;
  logic [W-1:0]   CfgPhase;
  logic [NCH-1:0] ClockOut;
  logic [NCH-1:0] RiseTick;
  logic [NCH-1:0] FallTick;
  logic [NCH-1:0] Running;

  clock_divider_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (W),
    .DEFAULT_HALF(DH),
    .INIT_STATE  (INIT)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .CfgWrite(CfgWrite),
    .CfgChan (CfgChan),
    .CfgHalf (CfgHalf),
    .CfgPhase(CfgPhase),
    .ClockOut(ClockOut),
    .RiseTick(RiseTick),
    .FallTick(FallTick),
    .Running (Running)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [NCH-1:0] co;
    logic [NCH-1:0] rt;
    logic [NCH-1:0] ft;
    logic [NCH-1:0] rn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // model: mode 0 idle, 1 start delay, 2 running
  int   mode[NCH];
  int   left[NCH];
  int   ha[NCH];
  int   sh[NCH];
  int   ps[NCH];
  logic lvl[NCH];

  task automatic step();
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      if (Reset) begin
        mode[c] = 0;
        left[c] = 0;
        ha[c]   = DH;
        sh[c]   = DH;
        ps[c]   = 0;
        lvl[c]  = INIT;
      end else begin
        if (CfgWrite && int'(CfgChan) == c) begin
          sh[c] = int'(CfgHalf);
          ps[c] = int'(CfgPhase);
        end
        case (mode[c])
          0: begin
            lvl[c] = INIT;
            ha[c]  = sh[c];
            if (Enable[c] && ha[c] != 0) begin
              if (ps[c] == 0) begin
                mode[c] = 2;
                left[c] = ha[c];
              end else begin
                mode[c] = 1;
                left[c] = ps[c];
              end
            end
          end
          1: begin
            if (!Enable[c]) begin
              mode[c] = 0;
            end else begin
              left[c]--;
              if (left[c] == 0) begin
                mode[c] = 2;
                left[c] = ha[c];
              end
            end
          end
          default: begin
            if (!Enable[c] && lvl[c] == INIT) begin
              mode[c] = 0;
            end else begin
              left[c]--;
              if (left[c] == 0) begin
                lvl[c] = ~lvl[c];
                if (lvl[c]) e.rt[c] = 1'b1;
                else        e.ft[c] = 1'b1;
                ha[c]   = sh[c];
                left[c] = ha[c];
                if (!Enable[c]) mode[c] = 0;
              end
            end
          end
        endcase
      end
      e.co[c] = lvl[c];
      e.rn[c] = (mode[c] != 0);
    end
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      step();
      @(negedge Clock);
    end
  endtask

  task automatic wcfg(input int ch, input int h, input int p);
    CfgWrite = 1'b1;
    CfgChan  = CW'(ch);
    CfgHalf  = W'(h);
    CfgPhase = W'(p);
    tick(1);
    CfgWrite = 1'b0;
  endtask

  // monitor: compare every presented output cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ClockOut !== e.co || RiseTick !== e.rt ||
            FallTick !== e.ft || Running !== e.rn) begin
          errors++;
          $display("FAIL outputs cyc %0d: got co=%b rt=%b ft=%b rn=%b want co=%b rt=%b ft=%b rn=%b",
                   cyc, ClockOut, RiseTick, FallTick, Running,
                   e.co, e.rt, e.ft, e.rn);
        end
      end
    end
  end

  initial begin
    Reset    = 1'b1;
    Enable   = '0;
    CfgWrite = 1'b0;
    CfgChan  = '0;
    CfgHalf  = '0;
    CfgPhase = '0;
    tick(2);
    Reset = 1'b0;
    tick(1);

    wcfg(5, 9, 0);
    wcfg(7, 9, 0);
    wcfg(4, 0, 0);
    Enable[4] = 1'b1;
    tick(4);
    wcfg(4, 3, 1);
    tick(10);
    Enable[4] = 1'b0;
    tick(8);

    Enable[0] = 1'b1;
    tick(9);
    wcfg(0, 1, 0);
    tick(10);

    wcfg(1, 3, 5);
    Enable[1] = 1'b1;
    tick(25);

    wcfg(2, 5, 0);
    Enable[2] = 1'b1;
    tick(7);
    wcfg(2, 2, 0);
    tick(16);

    wcfg(3, 4, 0);
    Enable[3] = 1'b1;
    tick(5);
    Enable[3] = 1'b0;
    tick(8);

    Enable = '1;
    tick(7);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    tick(10);

    for (int i = 0; i < 700; i++) begin
      Reset    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0)
        Enable[$urandom_range(0, NCH - 1)] ^= 1'b1;
      CfgWrite = ($urandom_range(0, 5) == 0);
      CfgChan  = CW'($urandom_range(0, 7));
      CfgHalf  = W'($urandom_range(1, 6));
      CfgPhase = W'($urandom_range(0, 4));
      tick(1);
    end
    Reset    = 1'b0;
    CfgWrite = 1'b0;
    tick(3);
    @(posedge Clock);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
